// File: rtl/counter_stream_checker.sv
// counter_stream_checker
// Receive-side checker for an incrementing counter stream. It seeds on the
// first valid sample and then needs LOCK_COUNT correct increments to lock.
// While locked, it pulses and counts mismatches and correct wraps to zero.
// Lock is dropped after LOSS_COUNT consecutive mismatches.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   data_in    sampled counter value (WIDTH bits)
//   valid_in   qualifies data_in; invalid cycles are ignored entirely
//   clear      synchronous clear of err_count and wrap_count only
//   locked     checker is locked to the stream
//   mismatch   one-cycle pulse: the last valid sample, taken while locked, was wrong
//   wrap       one-cycle pulse: the last valid sample, taken while locked, was a correct step to 0
//   expected   next value the checker expects
//   err_count  mismatches seen while locked, saturating at 255
//   wrap_count correct wraps seen while locked, modulo 256
module counter_stream_checker #(
    parameter int WIDTH      = 8,
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    input  logic             clear,
    output logic             locked,
    output logic             mismatch,
    output logic             wrap,
    output logic [WIDTH-1:0] expected,
    output logic [7:0]       err_count,
    output logic [7:0]       wrap_count
);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [3:0]       LOCK_C = 4'(LOCK_COUNT);
    localparam logic [3:0]       LOSS_C = 4'(LOSS_COUNT);
    localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};

    state_t           r_state;
    state_t           w_state_next;
    logic [3:0]       r_run;
    logic [3:0]       w_run_next;
    logic [3:0]       r_miss;
    logic [3:0]       w_miss_next;
    logic [WIDTH-1:0] r_expected;
    logic [WIDTH-1:0] w_expected_next;
    logic             r_locked;
    logic             r_mismatch;
    logic             r_wrap;
    logic [7:0]       r_err_count;
    logic [7:0]       r_wrap_count;
    logic             w_locked_next;
    logic             w_mismatch_next;
    logic             w_wrap_next;
    logic [7:0]       w_err_next;
    logic [7:0]       w_wrapc_next;

    logic             w_hit;
    logic [WIDTH-1:0] w_data_plus1;
    logic [WIDTH-1:0] w_exp_plus1;
    logic [3:0]       w_run_inc;
    logic [3:0]       w_miss_inc;

    assign w_hit        = (data_in == r_expected);
    assign w_data_plus1 = data_in + ONE_C;
    assign w_exp_plus1  = r_expected + ONE_C;
    assign w_run_inc    = r_run + 4'd1;
    assign w_miss_inc   = r_miss + 4'd1;

    // State and sequence-tracking registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_SEARCH;
            r_run      <= 4'd0;
            r_miss     <= 4'd0;
            r_expected <= ZERO_C;
        end else begin
            r_state    <= w_state_next;
            r_run      <= w_run_next;
            r_miss     <= w_miss_next;
            r_expected <= w_expected_next;
        end
    end

    // Next-state and sequence-tracking logic; advances only on valid samples
    always_comb begin
        w_state_next    = r_state;
        w_run_next      = r_run;
        w_miss_next     = r_miss;
        w_expected_next = r_expected;
        if (valid_in) begin
            case (r_state)
                ST_SEARCH: begin
                    w_expected_next = w_data_plus1;
                    w_run_next      = 4'd0;
                    w_state_next    = ST_VERIFY;
                end
                ST_VERIFY: begin
                    w_expected_next = w_data_plus1;
                    if (w_hit) begin
                        if (w_run_inc == LOCK_C) begin
                            w_run_next   = 4'd0;
                            w_miss_next  = 4'd0;
                            w_state_next = ST_LOCKED;
                        end else begin
                            w_run_next = w_run_inc;
                        end
                    end else begin
                        // Any break in VERIFY simply reseeds from the new sample
                        w_run_next = 4'd0;
                    end
                end
                ST_LOCKED: begin
                    if (w_hit) begin
                        w_expected_next = w_data_plus1;
                        w_miss_next     = 4'd0;
                    end else begin
                        // Free-run so that one corrupt sample does not shift the phase
                        w_expected_next = w_exp_plus1;
                        if (w_miss_inc == LOSS_C) begin
                            w_miss_next  = 4'd0;
                            w_run_next   = 4'd0;
                            w_state_next = ST_SEARCH;
                        end else begin
                            w_miss_next = w_miss_inc;
                        end
                    end
                end
                default: begin
                    w_state_next    = ST_SEARCH;
                    w_run_next      = 4'd0;
                    w_miss_next     = 4'd0;
                    w_expected_next = ZERO_C;
                end
            endcase
        end else begin
            w_state_next = r_state;
        end
    end

    // Output decode: pulses, lock flag and counters, registered below
    always_comb begin
        w_mismatch_next = valid_in && (r_state == ST_LOCKED) && !w_hit;
        w_wrap_next     = valid_in && (r_state == ST_LOCKED) && w_hit && (data_in == ZERO_C);
        w_locked_next   = (w_state_next == ST_LOCKED);
        // clear takes priority over a coincident increment
        if (clear) begin
            w_err_next   = 8'd0;
            w_wrapc_next = 8'd0;
        end else begin
            w_err_next   = (w_mismatch_next && (r_err_count != 8'hFF)) ? r_err_count + 8'd1 : r_err_count;
            w_wrapc_next = w_wrap_next ? r_wrap_count + 8'd1 : r_wrap_count;
        end
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_locked     <= 1'b0;
            r_mismatch   <= 1'b0;
            r_wrap       <= 1'b0;
            r_err_count  <= 8'd0;
            r_wrap_count <= 8'd0;
        end else begin
            r_locked     <= w_locked_next;
            r_mismatch   <= w_mismatch_next;
            r_wrap       <= w_wrap_next;
            r_err_count  <= w_err_next;
            r_wrap_count <= w_wrapc_next;
        end
    end

    assign locked     = r_locked;
    assign mismatch   = r_mismatch;
    assign wrap       = r_wrap;
    assign expected   = r_expected;
    assign err_count  = r_err_count;
    assign wrap_count = r_wrap_count;

endmodule

// File: tb/tb_counter_stream_checker.sv
// Testbench for counter_stream_checker. Every driven cycle pushes the
// reference model's predicted outputs into a queue. A monitor on the falling
// edge pops each entry and compares it with the DUT outputs. Directed
// scenarios add a few constant checks on top of that.
module tb_counter_stream_checker;

    localparam int LOCK_N = 4;
    localparam int LOSS_N = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'd0;
    logic       valid_in = 1'b0;
    logic       clear = 1'b0;
    logic       locked, mismatch, wrap;
    logic [7:0] expected, err_count, wrap_count;

    counter_stream_checker #(.WIDTH(8), .LOCK_COUNT(LOCK_N), .LOSS_COUNT(LOSS_N)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .clear(clear),
        .locked(locked), .mismatch(mismatch), .wrap(wrap), .expected(expected),
        .err_count(err_count), .wrap_count(wrap_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int l; int m; int w; int e; int ec; int wc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: mode 0 = searching, 1 = verifying, 2 = locked
    int m_mode = 0, m_run = 0, m_miss = 0, m_exp = 0, m_err = 0, m_wc = 0;

    function automatic void model(input bit r, input bit v, input bit c, input int d, output exp_t x);
        int mm = 0;
        int wr = 0;
        if (r) begin
            m_mode = 0; m_run = 0; m_miss = 0; m_exp = 0; m_err = 0; m_wc = 0;
        end else begin
            if (v) begin
                if (m_mode == 0) begin
                    m_exp = (d + 1) % 256; m_run = 0; m_mode = 1;
                end else if (m_mode == 1) begin
                    if (d == m_exp) begin
                        m_run++;
                        if (m_run == LOCK_N) begin m_mode = 2; m_run = 0; m_miss = 0; end
                    end else begin
                        m_run = 0;
                    end
                    m_exp = (d + 1) % 256;
                end else begin
                    if (d == m_exp) begin
                        m_exp = (d + 1) % 256; m_miss = 0;
                        if (d == 0) begin wr = 1; m_wc = (m_wc + 1) % 256; end
                    end else begin
                        mm = 1;
                        if (m_err < 255) m_err++;
                        m_exp = (m_exp + 1) % 256;
                        m_miss++;
                        if (m_miss == LOSS_N) begin m_mode = 0; m_miss = 0; m_run = 0; end
                    end
                end
            end
            if (c) begin m_err = 0; m_wc = 0; end
        end
        x.l = (m_mode == 2) ? 1 : 0; x.m = mm; x.w = wr;
        x.e = m_exp; x.ec = m_err; x.wc = m_wc;
    endfunction

    task automatic cmp(input string n, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d at %0t", n, act, req, $time);
        end
    endtask

    // Monitor: one prediction per driven edge, checked on the falling edge
    always @(negedge clk) begin
        exp_t x;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            cmp("sb_locked", int'(locked), x.l);
            cmp("sb_mismatch", int'(mismatch), x.m);
            cmp("sb_wrap", int'(wrap), x.w);
            cmp("sb_expected", int'(expected), x.e);
            cmp("sb_err_count", int'(err_count), x.ec);
            cmp("sb_wrap_count", int'(wrap_count), x.wc);
        end
    end

    task automatic step(input bit r, input bit v, input bit c, input int d);
        exp_t x;
        logic [7:0] d8;
        d8 = 8'(d);
        rst = r; valid_in = v; clear = c; data_in = d8;
        model(r, v, c, d, x);
        @(posedge clk);
        sb.push_back(x);
        #1;
    endtask

    // Reset, then lock so that the next expected value is x
    task automatic lock_at(input int x);
        step(1'b1, 1'b0, 1'b0, 0);
        for (int i = 5; i >= 1; i--) step(1'b0, 1'b1, 1'b0, (x - i + 256) % 256);
    endtask

    initial begin
        int e;
        int s;
        int k;
        int d;
        bit r, v, c;

        // Reset state
        step(1'b1, 1'b0, 1'b0, 0);
        step(1'b1, 1'b0, 1'b0, 0);
        cmp("rst_locked", int'(locked), 0);
        cmp("rst_expected", int'(expected), 0);
        cmp("rst_err", int'(err_count), 0);

        // 1: acquire lock on 10..14
        for (int i = 10; i <= 13; i++) step(1'b0, 1'b1, 1'b0, i);
        cmp("t1_not_locked_yet", int'(locked), 0);
        step(1'b0, 1'b1, 1'b0, 14);
        cmp("t1_locked", int'(locked), 1);
        cmp("t1_expected", int'(expected), 15);
        cmp("t1_err", int'(err_count), 0);

        // 2: single glitch while locked
        lock_at(100);
        step(1'b0, 1'b1, 1'b0, 100);
        step(1'b0, 1'b1, 1'b0, 101);
        step(1'b0, 1'b1, 1'b0, 77);
        cmp("t2_mismatch", int'(mismatch), 1);
        step(1'b0, 1'b1, 1'b0, 103);
        cmp("t2_mismatch_clear", int'(mismatch), 0);
        cmp("t2_err", int'(err_count), 1);
        cmp("t2_expected", int'(expected), 104);
        cmp("t2_locked", int'(locked), 1);

        // 3: two misses drop lock, then relock with err_count held
        lock_at(50);
        step(1'b0, 1'b1, 1'b0, 9);
        cmp("t3_locked_after_first", int'(locked), 1);
        step(1'b0, 1'b1, 1'b0, 9);
        cmp("t3_unlocked", int'(locked), 0);
        cmp("t3_mismatch2", int'(mismatch), 1);
        for (int i = 200; i <= 204; i++) step(1'b0, 1'b1, 1'b0, i);
        cmp("t3_relocked", int'(locked), 1);
        cmp("t3_err_held", int'(err_count), 2);

        // 4: wrap through 255 -> 0
        lock_at(254);
        step(1'b0, 1'b1, 1'b0, 254);
        step(1'b0, 1'b1, 1'b0, 255);
        step(1'b0, 1'b1, 1'b0, 0);
        cmp("t4_wrap", int'(wrap), 1);
        step(1'b0, 1'b1, 1'b0, 1);
        cmp("t4_wrap_once", int'(wrap), 0);
        cmp("t4_wrap_count", int'(wrap_count), 1);
        cmp("t4_err", int'(err_count), 0);
        cmp("t4_expected", int'(expected), 2);

        // 5: invalid samples are ignored
        lock_at(20);
        step(1'b0, 1'b1, 1'b0, 20);
        step(1'b0, 1'b0, 1'b0, 99);
        cmp("t5_no_mismatch_invalid", int'(mismatch), 0);
        step(1'b0, 1'b1, 1'b0, 21);
        cmp("t5_expected", int'(expected), 22);
        cmp("t5_err", int'(err_count), 0);

        // 5b: saturation by alternating bad and good samples, then clear vs mismatch
        lock_at(10);
        e = 10;
        for (int i = 0; i < 260; i++) begin
            step(1'b0, 1'b1, 1'b0, (e + 128) % 256); e = (e + 1) % 256;
            step(1'b0, 1'b1, 1'b0, e);               e = (e + 1) % 256;
        end
        cmp("t5_err_saturated", int'(err_count), 255);
        step(1'b0, 1'b1, 1'b0, (e + 128) % 256); e = (e + 1) % 256;
        cmp("t5_sat_mismatch", int'(mismatch), 1);
        cmp("t5_err_still_255", int'(err_count), 255);
        step(1'b0, 1'b1, 1'b0, e); e = (e + 1) % 256;
        step(1'b0, 1'b1, 1'b1, (e + 128) % 256);
        cmp("t5_clear_mismatch_pulse", int'(mismatch), 1);
        cmp("t5_clear_err", int'(err_count), 0);
        cmp("t5_clear_keeps_lock", int'(locked), 1);

        // 6: reset while locked with counts
        lock_at(60);
        step(1'b0, 1'b1, 1'b0, 1);  step(1'b0, 1'b1, 1'b0, 61);
        step(1'b0, 1'b1, 1'b0, 1);  step(1'b0, 1'b1, 1'b0, 63);
        step(1'b0, 1'b1, 1'b0, 1);  step(1'b0, 1'b1, 1'b0, 65);
        cmp("t6_err_pre", int'(err_count), 3);
        step(1'b1, 1'b1, 1'b0, 66);
        cmp("t6_locked", int'(locked), 0);
        cmp("t6_err", int'(err_count), 0);
        cmp("t6_wrapc", int'(wrap_count), 0);
        cmp("t6_expected", int'(expected), 0);
        step(1'b0, 1'b1, 1'b0, 42);
        cmp("t6_reseed", int'(expected), 43);
        cmp("t6_still_unlocked", int'(locked), 0);

        // Random phase: mostly clean counter stream with glitches, gaps, clears, resets
        s = $urandom_range(0, 255);
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 299) == 0);
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 59) == 0);
            d = ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, 255)) : s;
            if (v) s = (s + 1) % 256;
            step(r, v, c, d);
        end
        step(1'b0, 1'b0, 1'b0, 0);

        k = 0;
        while (sb.size() > 0 && k < 20) begin
            @(posedge clk);
            k++;
        end
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
